l2_line_adaptor: RTL and testbench

Physical-memory responder for the L2 cache: accepts whole-line read/write requests on the L2's pmem side and executes each as a fixed-length multi-beat burst on the narrower main-memory interface. Sits between the L2 controller's `pmem_read`/`pmem_write`/`pmem_resp` handshake and the DRAM/burst memory model. Handles one transaction at a time, with a single-cycle completion pulse back to the L2.

---
 rtl/l2_line_adaptor.sv | 183 ++++++++++++++++++
 tb/tb_l2_line_adaptor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_line_adaptor.sv
// l2_line_adaptor
// ---------------
// Physical-memory responder for the L2 cache. Accepts one whole-line read or
// write request at a time from the L2 pmem side and runs it as a fixed-length
// burst of BEATS = LINE_W/BEAT_W beats on the narrower burst-memory interface.
// Completion is a single-cycle line_resp pulse from the DONE state.
//
// Optional feature macro: L2_LINE_ADAPTOR_PERF_EN adds three 32-bit
// performance counters (read lines, write lines, busy cycles).
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   line_read/write   L2 request, held until line_resp
//   line_addr         line byte address (low offset bits ignored)
//   line_wdata        line to write
//   line_rdata        last completed read line (registered)
//   line_resp         one-cycle completion pulse
//   burst_read/write  burst request, held for the whole burst
//   burst_addr        line-aligned burst address
//   burst_wdata       current write beat
//   burst_rdata       read beat, valid with burst_resp
//   burst_resp        beat accepted/valid, one per beat
//   perf_*            (PERF_EN only) wrapping 32-bit counters
module l2_line_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef L2_LINE_ADAPTOR_PERF_EN
  output logic [31:0]       perf_rd_lines,
  output logic [31:0]       perf_wr_lines,
  output logic [31:0]       perf_busy_cycles,
`endif
  input  logic              line_read,
  input  logic              line_write,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  // Masking (rather than slicing) keeps every address bit in use.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e              state_r;
  state_e              state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [LINE_W-1:0]   wline_r;
  logic [LINE_W-1:0]   rline_r;
  logic                last_beat_s;

  assign last_beat_s = burst_resp && (cnt_r == CNT_W'(BEATS - 1));

  // Next-state logic: read wins over write in IDLE; DONE never samples requests.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (line_read) begin
          state_s = RD_BURST;
        end else if (line_write) begin
          state_s = WR_BURST;
        end else begin
          state_s = IDLE;
        end
      end
      RD_BURST: begin
        if (last_beat_s) begin
          state_s = DONE;
        end else begin
          state_s = RD_BURST;
        end
      end
      WR_BURST: begin
        if (last_beat_s) begin
          state_s = DONE;
        end else begin
          state_s = WR_BURST;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, beat counter, latched request and assembled read line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      wline_r <= {LINE_W{1'b0}};
      rline_r <= {LINE_W{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          // cnt is held at zero while idle, so each burst starts from beat 0.
          cnt_r <= {CNT_W{1'b0}};
          if (line_read) begin
            addr_r <= line_addr & ADDR_MASK;
          end else if (line_write) begin
            addr_r  <= line_addr & ADDR_MASK;
            wline_r <= line_wdata;
          end
        end
        RD_BURST: begin
          if (burst_resp) begin
            rline_r[int'(cnt_r) * BEAT_W +: BEAT_W] <= burst_rdata;
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WR_BURST: begin
          if (burst_resp) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign line_rdata  = rline_r;
  assign line_resp   = (state_r == DONE);
  assign burst_read  = (state_r == RD_BURST);
  assign burst_write = (state_r == WR_BURST);
  assign burst_addr  = addr_r;
  assign burst_wdata = wline_r[int'(cnt_r) * BEAT_W +: BEAT_W];

`ifdef L2_LINE_ADAPTOR_PERF_EN
  logic        txn_rd_r;
  logic [31:0] perf_rd_r;
  logic [31:0] perf_wr_r;
  logic [31:0] perf_busy_r;

  // Performance counters; txn_rd_r remembers the accepted transaction type.
  always_ff @(posedge clk) begin
    if (!rst) begin
      txn_rd_r    <= 1'b0;
      perf_rd_r   <= 32'd0;
      perf_wr_r   <= 32'd0;
      perf_busy_r <= 32'd0;
    end else begin
      if (state_r == IDLE) begin
        txn_rd_r <= line_read;
      end else begin
        perf_busy_r <= perf_busy_r + 32'd1;
      end
      if (state_r == DONE) begin
        if (txn_rd_r) begin
          perf_rd_r <= perf_rd_r + 32'd1;
        end else begin
          perf_wr_r <= perf_wr_r + 32'd1;
        end
      end
    end
  end

  assign perf_rd_lines    = perf_rd_r;
  assign perf_wr_lines    = perf_wr_r;
  assign perf_busy_cycles = perf_busy_r;
`endif

endmodule

// File: tb/tb_l2_line_adaptor.sv
// Directed, table-driven bench for l2_line_adaptor (LINE_W=256, BEAT_W=64).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_l2_line_adaptor;

  logic         clk;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
`ifdef L2_LINE_ADAPTOR_PERF_EN
  logic [31:0]  perf_rd_lines;
  logic [31:0]  perf_wr_lines;
  logic [31:0]  perf_busy_cycles;
`endif

  int errors = 0;
  int checks = 0;

  l2_line_adaptor #(.LINE_W(256), .BEAT_W(64), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef L2_LINE_ADAPTOR_PERF_EN
    .perf_rd_lines    (perf_rd_lines),
    .perf_wr_lines    (perf_wr_lines),
    .perf_busy_cycles (perf_busy_cycles),
`endif
    .line_read   (line_read),
    .line_write  (line_write),
    .line_addr   (line_addr),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_addr  (burst_addr),
    .burst_wdata (burst_wdata),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] wd;
    logic [255:0] rline;
    int           gap;
    logic [31:0]  exp_addr;
    logic [255:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request at the current falling edge; after acceptance scramble
  // the address/data to show they are not re-sampled.
  task automatic issue(input bit rd, input logic [31:0] addr, input logic [255:0] wd);
    line_read  = rd;
    line_write = !rd;
    line_addr  = addr;
    line_wdata = wd;
    @(negedge clk);
    line_addr  = ~addr;
    line_wdata = ~wd;
  endtask

  // Act as burst memory for one transaction already in progress; gap is the
  // number of wait cycles before each beat. Checks beat data, address,
  // completion timing and line_rdata. With chain set, a read of ch_addr is
  // raised in the DONE cycle.
  task automatic burst_phase(input bit rd, input logic [255:0] wd, input logic [255:0] rline,
                             input int gap, input logic [31:0] exp_addr,
                             input logic [255:0] exp_rdata, input bit chain,
                             input logic [31:0] ch_addr);
    int beat = 0;
    int w = 0;
    int cyc = 0;
    while (beat < 4 && cyc < 100) begin
      check("burst_read", burst_read, rd);
      check("burst_write", burst_write, !rd);
      check("burst_addr", burst_addr, exp_addr);
      check("line_resp_busy", line_resp, 1'b0);
      if (!rd) check("burst_wdata", burst_wdata, wd[beat*64 +: 64]);
      if (w == gap) begin
        burst_resp  = 1'b1;
        burst_rdata = rline[beat*64 +: 64];
        beat++;
        w = 0;
      end else begin
        burst_resp  = 1'b0;
        burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        w++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) check("burst_timeout", 1'b1, 1'b0);
    burst_resp = 1'b0;
    check("line_resp_done", line_resp, 1'b1);
    check("burst_read_done", burst_read, 1'b0);
    check("burst_write_done", burst_write, 1'b0);
    check("line_rdata", line_rdata, exp_rdata);
    if (chain) begin
      line_read  = 1'b1;
      line_write = 1'b0;
      line_addr  = ch_addr;
      @(negedge clk);
      check("line_resp_gap", line_resp, 1'b0);
      check("burst_read_gap", burst_read, 1'b0);
      @(negedge clk);
      line_addr = ~ch_addr;
    end else begin
      line_read  = 1'b0;
      line_write = 1'b0;
      @(negedge clk);
      check("line_resp_idle", line_resp, 1'b0);
      check("line_rdata_hold", line_rdata, exp_rdata);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, line_rdata, 256'd0);
    check({tag, "_resp"}, line_resp, 1'b0);
    check({tag, "_bread"}, burst_read, 1'b0);
    check({tag, "_bwrite"}, burst_write, 1'b0);
    check({tag, "_baddr"}, burst_addr, 32'd0);
    check({tag, "_bwdata"}, burst_wdata, 64'd0);
  endtask

  logic [255:0] r0_line, r2_line, r4_line, r5_line, rst_line, pf_line;

  initial begin
    r0_line  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    r2_line  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_0F0F_F0F0_F0F0};
    r4_line  = {64'h8888_7777_6666_5555, 64'h0000_0000_0000_0001,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h1357_9BDF_2468_ACE0};
    r5_line  = {64'h5555_0000_5555_0000, 64'h6666_0000_6666_0000,
                64'h7777_0000_7777_0000, 64'h8888_0000_8888_0000};
    rst_line = {64'hAAAA_0003_AAAA_0003, 64'hAAAA_0002_AAAA_0002,
                64'hAAAA_0001_AAAA_0001, 64'hAAAA_0000_AAAA_0000};
    pf_line  = {64'h0F00_0000_0000_0003, 64'h0F00_0000_0000_0002,
                64'h0F00_0000_0000_0001, 64'h0F00_0000_0000_0000};

    vecs[0] = '{1'b1, 32'h0000_1234, 256'd0, r0_line, 0, 32'h0000_1220, r0_line};
    vecs[1] = '{1'b0, 32'h0000_ABCF,
                {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                 64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0},
                256'd0, 2, 32'h0000_ABC0, r0_line};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 256'd0, r2_line, 1, 32'hFFFF_FFE0, r2_line};
    vecs[3] = '{1'b0, 32'h8000_001F,
                {64'hCAFE_CAFE_CAFE_CAFE, 64'hBEEF_BEEF_BEEF_BEEF,
                 64'h1234_1234_1234_1234, 64'h5678_5678_5678_5678},
                256'd0, 0, 32'h8000_0000, r2_line};
    vecs[4] = '{1'b1, 32'h0000_0040, 256'd0, r4_line, 3, 32'h0000_0040, r4_line};

    // Reset held two cycles with a read pending: nothing may start.
    rst = 1'b0;
    line_read = 1'b1;
    line_write = 1'b0;
    line_addr = 32'h0000_0100;
    line_wdata = 256'd0;
    burst_rdata = 64'd0;
    burst_resp = 1'b0;
    @(negedge clk);
    check_all_zero("rst1");
    @(negedge clk);
    check_all_zero("rst2");
    // Release: the held read is accepted at the next edge.
    rst = 1'b1;
    @(negedge clk);
    line_addr = 32'h0000_0000;
    burst_phase(1'b1, 256'd0, rst_line, 0, 32'h0000_0100, rst_line, 1'b0, 32'd0);

    // Table of single transactions with varying wait states and addresses.
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].rd, vecs[i].addr, vecs[i].wd);
      burst_phase(vecs[i].rd, vecs[i].wd, vecs[i].rline, vecs[i].gap,
                  vecs[i].exp_addr, vecs[i].exp_rdata, 1'b0, 32'd0);
    end

    // Writeback then allocate: read raised the cycle after line_resp.
    issue(1'b0, 32'h0000_0200, r2_line);
    burst_phase(1'b0, r2_line, 256'd0, 0, 32'h0000_0200, r4_line, 1'b1, 32'h0000_03FF);
    burst_phase(1'b1, 256'd0, r5_line, 0, 32'h0000_03E0, r5_line, 1'b0, 32'd0);

    // Reset mid-read after two beats: partial line discarded, no line_resp.
    issue(1'b1, 32'h0000_0500, 256'd0);
    for (int b = 0; b < 2; b++) begin
      burst_resp  = 1'b1;
      burst_rdata = 64'h9999_0000_0000_0000 | 64'(b);
      @(negedge clk);
    end
    burst_resp = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b1;
    line_read = 1'b0;
    // Stray burst_resp while idle must be ignored.
    burst_resp = 1'b1;
    burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_resp", line_resp, 1'b0);
      check("idle_bread", burst_read, 1'b0);
      check("idle_rdata", line_rdata, 256'd0);
    end
    burst_resp = 1'b0;

`ifdef L2_LINE_ADAPTOR_PERF_EN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("perf_rst", perf_busy_cycles, 32'd0);
    for (int t = 0; t < 5; t++) begin
      if (t % 2 == 0) begin
        issue(1'b1, 32'h0000_1000, 256'd0);
        burst_phase(1'b1, 256'd0, pf_line, 0, 32'h0000_1000, pf_line, 1'b0, 32'd0);
      end else begin
        issue(1'b0, 32'h0000_2000, r0_line);
        burst_phase(1'b0, r0_line, 256'd0, 0, 32'h0000_2000, pf_line, 1'b0, 32'd0);
      end
    end
    check("perf_rd_lines", perf_rd_lines, 32'd3);
    check("perf_wr_lines", perf_wr_lines, 32'd2);
    check("perf_busy_cycles", perf_busy_cycles, 32'd25);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
